// File: rtl/gray_pkg.sv
// Shared Gray-code helpers: width-generic conversions on a 32-bit word
// (narrower values are zero-extended) and the max-count constant.
package gray_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // All-ones value for a counter of the given width (1..MAX_WIDTH).
    function automatic word_t max_count(input int unsigned width);
        return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // Leading zeros of a zero-extended code leave the prefix chain untouched.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b = '0;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = int'(MAX_WIDTH) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter: XOR prefix chain from the MSB down.
module gray2bin #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule

// File: rtl/gray_counter_param.sv
// Up/down Gray counter with wrap/saturate modes, Gray-coded load and
// registered Gray and binary outputs.
module gray_counter_param #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] B_MAX = WIDTH'(gray_pkg::max_count(WIDTH));

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] gray_next;
    logic [WIDTH-1:0] load_bin;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    gray2bin #(.WIDTH(WIDTH)) u_load_g2b (
        .gray (load_val),
        .bin  (load_bin)
    );

    assign at_max  = (b == B_MAX);
    assign at_zero = (b == '0);

    // Next count: load beats enable; end-of-range either wraps (pulsing wrap) or holds.
    always_comb begin
        b_next    = b;
        wrap_next = 1'b0;
        if (load) begin
            b_next = load_bin;
        end else if (en) begin
            if (up) begin
                if (!at_max) begin
                    b_next = b + WIDTH'(1);
                end else if (!sat) begin
                    b_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (!at_zero) begin
                    b_next = b - WIDTH'(1);
                end else if (!sat) begin
                    b_next    = B_MAX;
                    wrap_next = 1'b1;
                end
            end
        end
        gray_next = WIDTH'(gray_pkg::bin2gray(32'(b_next)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b    <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            b    <= b_next;
            gray <= gray_next;
            wrap <= wrap_next;
        end
    end

    assign bin = b;
    assign tc  = up ? at_max : at_zero;

endmodule

// File: tb/tb_gray_counter_param.sv
// Self-checking bench for gray_counter_param at WIDTH 4 (directed), 1 and 8 (random).
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
    logic [3:0] lv4 = '0;
    logic [0:0] lv1 = '0;
    logic [7:0] lv8 = '0;
    logic [3:0] g4, b4;
    logic [0:0] g1, b1;
    logic [7:0] g8, b8;
    logic       tc4, w4, tc1, w1, tc8, w8;

    gray_counter_param #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(lv4), .gray(g4), .bin(b4), .tc(tc4), .wrap(w4));
    gray_counter_param #(.WIDTH(1)) u1 (.clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(lv1), .gray(g1), .bin(b1), .tc(tc1), .wrap(w1));
    gray_counter_param #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .en(en), .up(up), .sat(sat),
        .load(load), .load_val(lv8), .gray(g8), .bin(b8), .tc(tc8), .wrap(w8));

    always #5 clk = ~clk;

    typedef struct {
        logic       load, en, up, sat;
        logic [3:0] lv;
        logic [3:0] gray, bin;
        logic       wrap, tc;
    } vec_t;

    typedef struct {
        logic [31:0] gray, bin;
        logic        wrap;
    } exp_t;

    exp_t q4[$], q1[$], q8[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic ld, input logic e, input logic u, input logic s,
                                input logic [3:0] lv, input logic [3:0] g, input logic [3:0] b,
                                input logic w, input logic t);
        vec_t v;
        v.load = ld; v.en = e; v.up = u; v.sat = s; v.lv = lv;
        v.gray = g; v.bin = b; v.wrap = w; v.tc = t;
        return v;
    endfunction

    function automatic logic [31:0] b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Reference model: returns {wrap, next binary count}.
    function automatic logic [32:0] model(input int w, input logic [31:0] b, input logic ld,
                                          input logic [31:0] lvg, input logic e,
                                          input logic u, input logic s);
        logic [31:0] mx;
        logic [31:0] lb;
        logic        acc;
        mx  = (32'd1 << w) - 32'd1;
        lb  = '0;
        acc = 1'b0;
        if (ld) begin
            for (int i = w - 1; i >= 0; i--) begin
                acc   = acc ^ lvg[i];
                lb[i] = acc;
            end
            return {1'b0, lb};
        end
        if (!e) return {1'b0, b};
        if (u) begin
            if (b == mx) return s ? {1'b0, b} : {1'b1, 32'd0};
            return {1'b0, b + 32'd1};
        end
        if (b == 32'd0) return s ? {1'b0, 32'd0} : {1'b1, mx};
        return {1'b0, b - 32'd1};
    endfunction

    // Drive one WIDTH=4 vector, check tc before the edge, then the registered result.
    task automatic apply4(input vec_t v, input string name);
        exp_t e;
        load = v.load; en = v.en; up = v.up; sat = v.sat; lv4 = v.lv;
        e.gray = 32'(v.gray); e.bin = 32'(v.bin); e.wrap = v.wrap;
        q4.push_back(e);
        #1 chk({name, " tc"}, 32'(tc4), 32'(v.tc));
        @(posedge clk);
        #1;
        e = q4.pop_front();
        chk({name, " gray"}, 32'(g4), e.gray);
        chk({name, " bin"},  32'(b4), e.bin);
        chk({name, " wrap"}, 32'(w4), 32'(e.wrap));
    endtask

    task automatic pulse_reset();
        load = 1'b0; en = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  gseq [16];
        vec_t        tbl  [16];
        logic [32:0] r;
        logic [31:0] m1, m8, p1, p8;
        exp_t        e;

        // Reset state, asynchronous and before any clock edge
        #2;
        chk("rst g4", 32'(g4), 32'd0);
        chk("rst b4", 32'(b4), 32'd0);
        chk("rst w4", 32'(w4), 32'd0);
        chk("rst g8", 32'(g8), 32'd0);
        up = 1'b0;
        #1 chk("rst tc down", 32'(tc4), 32'd1);
        up = 1'b1;
        #1 chk("rst tc up", 32'(tc4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full wrapping up-count sequence
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, gseq[i], 4'(i + 1), i == 15, i == 15);
        for (int i = 0; i < 16; i++)
            apply4(tbl[i], $sformatf("seq%0d", i));

        // Down from zero wraps to max, then hold
        pulse_reset();
        apply4(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'b1000, 4'hf, 1'b1, 1'b1), "down_wrap");
        apply4(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'b1000, 4'hf, 1'b0, 1'b0), "hold");

        // Saturate at max after a Gray load
        apply4(mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 4'b1000, 4'hf, 1'b0, 1'b1), "sat_load");
        for (int i = 0; i < 5; i++)
            apply4(mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'b1000, 4'hf, 1'b0, 1'b1),
                   $sformatf("sat_hold%0d", i));

        // Saturate at zero counting down
        pulse_reset();
        apply4(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'b0000, 4'h0, 1'b0, 1'b1), "sat_zero");

        // Load wins over enable; load at max never raises wrap
        pulse_reset();
        apply4(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0001, 4'd1, 1'b0, 1'b0), "cnt1");
        apply4(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0011, 4'd2, 1'b0, 1'b0), "cnt2");
        apply4(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0010, 4'd3, 1'b0, 1'b0), "cnt3");
        apply4(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'd4, 1'b0, 1'b0), "load_wins");
        apply4(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 4'b1000, 4'hf, 1'b0, 1'b0), "load_max");
        apply4(mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'h0, 1'b0, 1'b1), "load_nowrap");

        // Asynchronous reset mid-count discards a pending load
        pulse_reset();
        for (int k = 1; k <= 9; k++)
            apply4(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(b2g(32'(k))), 4'(k), 1'b0, 1'b0),
                   $sformatf("pre_rst%0d", k));
        load = 1'b1; lv4 = 4'b1111; en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async g4", 32'(g4), 32'd0);
        chk("async b4", 32'(b4), 32'd0);
        chk("async w4", 32'(w4), 32'd0);
        @(posedge clk);
        #1 chk("rst_hold g4", 32'(g4), 32'd0);
        rst = 1'b0; load = 1'b0;
        apply4(mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'b0001, 4'd1, 1'b0, 1'b0), "resume");

        // Random traffic on WIDTH=1 and WIDTH=8 against the model
        pulse_reset();
        m1 = '0; m8 = '0;
        for (int n = 0; n < 400; n++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            sat  = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 9) == 0);
            lv1  = 1'($urandom_range(0, 1));
            lv8  = 8'($urandom_range(0, 255));
            r = model(1, m1, load, 32'(lv1), en, up, sat);
            m1 = r[31:0];
            e.bin = m1; e.gray = b2g(m1); e.wrap = r[32];
            q1.push_back(e);
            r = model(8, m8, load, 32'(lv8), en, up, sat);
            m8 = r[31:0];
            e.bin = m8; e.gray = b2g(m8); e.wrap = r[32];
            q8.push_back(e);
            p1 = 32'(g1); p8 = 32'(g8);
            @(posedge clk);
            #1;
            e = q1.pop_front();
            chk("w1 gray", 32'(g1), e.gray);
            chk("w1 bin",  32'(b1), e.bin);
            chk("w1 wrap", 32'(w1), 32'(e.wrap));
            chk("w1 g=b", 32'(g1), 32'(b1));
            e = q8.pop_front();
            chk("w8 gray", 32'(g8), e.gray);
            chk("w8 bin",  32'(b8), e.bin);
            chk("w8 wrap", 32'(w8), 32'(e.wrap));
            chk("w8 coding", 32'(g8), b2g(32'(b8)));
            if (!load) begin
                chk("w1 onebit", 32'($countones(p1 ^ 32'(g1)) <= 1), 32'd1);
                chk("w8 onebit", 32'($countones(p8 ^ 32'(g8)) <= 1), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
